// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_pkg
// Purpose : Shared types and constants for the memory arbiter: address-map
//           region bounds, region/state/owner enumerations and a range helper.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package mem_pkg;

  localparam logic [31:0] ROM_BASE    = 32'h0000_0000;
  localparam logic [31:0] ROM_LIMIT   = 32'h0FFF_FFFF;
  localparam logic [31:0] RAM_BASE    = 32'h1000_0000;
  localparam logic [31:0] RAM_LIMIT   = 32'h1FFF_FFFF;
  localparam logic [31:0] STACK_BASE  = 32'hD000_0000;
  localparam logic [31:0] STACK_LIMIT = 32'hDFFF_FFFF;

  typedef enum logic [1:0] {
    REGION_ROM      = 2'd0,
    REGION_RAM      = 2'd1,
    REGION_STACK    = 2'd2,
    REGION_UNMAPPED = 2'd3
  } region_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_e;

  function automatic logic in_range(input logic [31:0] a,
                                    input logic [31:0] lo,
                                    input logic [31:0] hi);
    return (a >= lo) && (a <= hi);
  endfunction

endpackage
`default_nettype wire

// File: rtl/addr_decode.sv
`default_nettype none
// ============================================================================
// Module  : addr_decode
// Purpose : Combinational address-map decode for the granted access.
// Ports   : addr   in  32  access address
//           we     in  1   write enable of the access
//           owner  in  1   requesting port (I or D)
//           region out 2   decoded region
//           fault  out 1   unmapped address or data write into ROM
// Rev     : 1.0  initial release
// ============================================================================
module addr_decode
  import mem_pkg::*;
(
  input  logic [31:0] addr,
  input  logic        we,
  input  owner_e      owner,
  output region_e     region,
  output logic        fault
);

  always_comb begin
    region = REGION_UNMAPPED;
    if (in_range(addr, ROM_BASE, ROM_LIMIT))
      region = REGION_ROM;
    else if (in_range(addr, RAM_BASE, RAM_LIMIT))
      region = REGION_RAM;
    else if (in_range(addr, STACK_BASE, STACK_LIMIT))
      region = REGION_STACK;

    fault = (region == REGION_UNMAPPED) ||
            ((owner == OWNER_D) && we && (region == REGION_ROM));
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter
// Purpose : Arbitrates an instruction-fetch port and a data port onto one
//           single-port memory backend. Round-robin on conflict, address-map
//           fault detection, and a backend acknowledge timeout.
// Ports   : clk, reset                 clock / async active-high reset
//           iReq,iAddr -> iReady,iData,iErr          fetch port
//           dReq,dWe,dAddr,dWData -> dReady,dRData,dErr  data port
//           mReq,mWe,mAddr,mWData <- mAck,mRData     backend port
// Rev     : 1.0  initial release
// ============================================================================
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iReq,
  input  logic [31:0] iAddr,
  output logic        iReady,
  output logic [31:0] iData,
  output logic        iErr,
  input  logic        dReq,
  input  logic        dWe,
  input  logic [31:0] dAddr,
  input  logic [31:0] dWData,
  output logic        dReady,
  output logic [31:0] dRData,
  output logic        dErr,
  output logic        mReq,
  output logic        mWe,
  output logic [31:0] mAddr,
  output logic [31:0] mWData,
  input  logic        mAck,
  input  logic [31:0] mRData
);

  state_e      state, state_next;
  owner_e      last_grant, owner;
  logic [31:0] acc_addr, acc_wdata;
  logic        acc_we, acc_err;
  logic [3:0]  tmo_cnt;
  logic [31:0] fetch_data, load_data;

  // Candidate access seen in IDLE; on conflict the port not served last wins.
  logic        grant_valid;
  owner_e      grant_owner;
  logic [31:0] grant_addr, grant_wdata;
  logic        grant_we, grant_fault;
  region_e     unused_region;
  logic        timed_out;

  assign grant_valid = iReq | dReq;
  assign grant_owner = (iReq && dReq) ?
                         ((last_grant == OWNER_I) ? OWNER_D : OWNER_I) :
                         (dReq ? OWNER_D : OWNER_I);
  assign grant_addr  = (grant_owner == OWNER_D) ? dAddr : iAddr;
  assign grant_we    = (grant_owner == OWNER_D) && dWe;
  assign grant_wdata = (grant_owner == OWNER_D) ? dWData : 32'h0;

  // Region is informational only; fault already folds in the unmapped case.
  addr_decode u_addr_decode (
    .addr   (grant_addr),
    .we     (grant_we),
    .owner  (grant_owner),
    .region (unused_region),
    .fault  (grant_fault)
  );

  // Last ISSUE cycle allowed without mAck: the counter reaches TIMEOUT here.
  assign timed_out = (tmo_cnt == 4'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    mReq       = 1'b0;
    iReady     = 1'b0;
    dReady     = 1'b0;
    iErr       = 1'b0;
    dErr       = 1'b0;
    case (state)
      ST_IDLE:  if (grant_valid) state_next = grant_fault ? ST_RESP : ST_ISSUE;
      ST_ISSUE: begin
        mReq = 1'b1;
        if (mAck || timed_out) state_next = ST_RESP;
      end
      ST_RESP: begin
        state_next = ST_IDLE;
        iReady     = (owner == OWNER_I);
        dReady     = (owner == OWNER_D);
        iErr       = (owner == OWNER_I) && acc_err;
        dErr       = (owner == OWNER_D) && acc_err;
      end
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= OWNER_I;
      owner      <= OWNER_I;
      acc_addr   <= 32'h0;
      acc_wdata  <= 32'h0;
      acc_we     <= 1'b0;
      acc_err    <= 1'b0;
      tmo_cnt    <= 4'd0;
      fetch_data <= 32'h0;
      load_data  <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: if (grant_valid) begin
          owner      <= grant_owner;
          last_grant <= grant_owner;
          acc_addr   <= grant_addr;
          acc_we     <= grant_we;
          acc_wdata  <= grant_wdata;
          acc_err    <= grant_fault;
          tmo_cnt    <= 4'd0;
          // A faulting access goes straight to RESP with zero data.
          if (grant_fault) begin
            if (grant_owner == OWNER_D) load_data  <= 32'h0;
            else                        fetch_data <= 32'h0;
          end
        end
        ST_ISSUE: begin
          if (mAck) begin
            acc_err <= 1'b0;
            if (owner == OWNER_D) load_data  <= acc_we ? 32'h0 : mRData;
            else                  fetch_data <= mRData;
          end else begin
            tmo_cnt <= tmo_cnt + 4'd1;
            if (timed_out) begin
              acc_err <= 1'b1;
              if (owner == OWNER_D) load_data  <= 32'h0;
              else                  fetch_data <= 32'h0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign mWe    = acc_we;
  assign mAddr  = acc_addr;
  assign mWData = acc_wdata;
  assign iData  = fetch_data;
  assign dRData = load_data;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_arbiter
// Purpose : Self-checking bench for mem_arbiter: table of single accesses,
//           plus arbitration, timeout and reset-abort sequences. Completions
//           are checked against a queue of expected responses.
// Rev     : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        iReq = 1'b0, dReq = 1'b0, dWe = 1'b0, mAck = 1'b0;
  logic [31:0] iAddr = 32'h0, dAddr = 32'h0, dWData = 32'h0, mRData = 32'h0;
  logic        iReady, iErr, dReady, dErr, mReq, mWe;
  logic [31:0] iData, dRData, mAddr, mWData;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT(15)) dut (
    .clk(clk), .reset(reset),
    .iReq(iReq), .iAddr(iAddr), .iReady(iReady), .iData(iData), .iErr(iErr),
    .dReq(dReq), .dWe(dWe), .dAddr(dAddr), .dWData(dWData),
    .dReady(dReady), .dRData(dRData), .dErr(dErr),
    .mReq(mReq), .mWe(mWe), .mAddr(mAddr), .mWData(mWData),
    .mAck(mAck), .mRData(mRData)
  );

  int n_cmp = 0, n_bad = 0, n_ready = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- backend model: acks after ack_lat ISSUE cycles --------
  bit          back_en = 1'b1, force_ack = 1'b0, seen_mwe = 1'b0;
  int          ack_lat = 1, wait_cnt = 0, mreq_cycles = 0;
  logic [31:0] def_rdata = 32'h0;
  logic [31:0] mem [logic [31:0]];

  always @(negedge clk) begin
    mAck   = force_ack;
    mRData = 32'h0;
    if (mReq) begin
      mreq_cycles++;
      seen_mwe = mWe;
      if (back_en) begin
        wait_cnt++;
        if (wait_cnt == ack_lat) begin
          mAck = 1'b1;
          if (mWe) mem[mAddr] = mWData;
          else     mRData = mem.exists(mAddr) ? mem[mAddr] : def_rdata;
        end
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // ---------------- scoreboard ---------------------------------------------
  typedef struct { bit d; logic [31:0] data; bit err; } exp_t;
  exp_t sb[$];

  always @(negedge clk) begin
    if (reset === 1'b0 && (iReady || dReady)) begin
      exp_t e;
      n_ready++;
      check("one_ready", 32'(iReady & dReady), 32'd0);
      check("sb_pending", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("resp_port", 32'(dReady), 32'(e.d));
        check("resp_data", dReady ? dRData : iData, e.data);
        check("resp_err", 32'(dReady ? dErr : iErr), 32'(e.err));
      end
    end
  end

  // Drive one access (call at a negedge) and hold it until its ready pulse.
  task automatic do_txn(input bit d, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, output int lat);
    bit got = 1'b0;
    lat = 0;
    if (d) begin dWe = we; dAddr = addr; dWData = wdata; dReq = 1'b1; end
    else   begin iAddr = addr; iReq = 1'b1; end
    while (!got && lat < 100) begin
      @(negedge clk);
      lat++;
      got = d ? dReady : iReady;
    end
    check("ready_seen", 32'(got), 32'd1);
    if (d) begin dReq = 1'b0; dWe = 1'b0; end
    else   iReq = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    bit d; bit we; logic [31:0] addr; logic [31:0] wdata; logic [31:0] rdata;
    int lat; logic [31:0] exp_data; bit exp_err; bit exp_mreq;
  } vec_t;
  vec_t vecs[12];

  initial begin
    int lat, l1, l2, l3, n0;
    vecs[0]  = '{0, 0, 32'h0000_0004, 32'h0, 32'h1234_5678, 1, 32'h1234_5678, 0, 1};
    vecs[1]  = '{1, 1, 32'hDFFF_FF10, 32'hDEAD_BEEF, 32'h0, 1, 32'h0, 0, 1};
    vecs[2]  = '{1, 0, 32'hDFFF_FF10, 32'h0, 32'hAAAA_AAAA, 2, 32'hDEAD_BEEF, 0, 1};
    vecs[3]  = '{1, 1, 32'h0000_0010, 32'h7777_7777, 32'h0, 1, 32'h0, 1, 0};
    vecs[4]  = '{0, 0, 32'h2000_0000, 32'h0, 32'h9999_9999, 1, 32'h0, 1, 0};
    vecs[5]  = '{1, 0, 32'h1000_0040, 32'h0, 32'hCAFE_F00D, 3, 32'hCAFE_F00D, 0, 1};
    vecs[6]  = '{0, 0, 32'h0FFF_FFFC, 32'h0, 32'h1111_2222, 2, 32'h1111_2222, 0, 1};
    vecs[7]  = '{1, 0, 32'h1FFF_FFFC, 32'h0, 32'h3333_4444, 1, 32'h3333_4444, 0, 1};
    vecs[8]  = '{1, 0, 32'hE000_0000, 32'h0, 32'h4444_5555, 1, 32'h0, 1, 0};
    vecs[9]  = '{0, 0, 32'hD000_0000, 32'h0, 32'h5555_6666, 1, 32'h5555_6666, 0, 1};
    vecs[10] = '{1, 1, 32'h1000_0000, 32'h0BAD_CAFE, 32'h0, 2, 32'h0, 0, 1};
    vecs[11] = '{1, 0, 32'hCFFF_FFFC, 32'h0, 32'h6666_7777, 1, 32'h0, 1, 0};

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_ctrl", 32'({mReq, mWe, iReady, dReady, iErr, dErr}), 32'd0);
    check("rst_idata", iData, 32'h0);
    check("rst_drdata", dRData, 32'h0);
    check("rst_maddr", mAddr, 32'h0);
    check("rst_mwdata", mWData, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Single accesses from the table
    for (int i = 0; i < 12; i++) begin
      def_rdata   = vecs[i].rdata;
      ack_lat     = vecs[i].lat;
      mreq_cycles = 0;
      sb.push_back('{vecs[i].d, vecs[i].exp_data, vecs[i].exp_err});
      do_txn(vecs[i].d, vecs[i].we, vecs[i].addr, vecs[i].wdata, lat);
      check("mreq_cycles", 32'(mreq_cycles), vecs[i].exp_mreq ? 32'(vecs[i].lat) : 32'd0);
      check("latency", 32'(lat), vecs[i].exp_mreq ? 32'(vecs[i].lat + 1) : 32'd1);
      if (vecs[i].exp_mreq) check("mwe", 32'(seen_mwe), 32'(vecs[i].we));
    end
    check("idata_hold", iData, 32'h5555_6666);

    // Conflict from reset: D first, then I; D re-requesting meets I-pending -> I wins
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    ack_lat = 1;
    mem[32'h0000_0008] = 32'h0000_8888;
    mem[32'h1000_0010] = 32'h1010_1010;
    mem[32'h1000_0014] = 32'h1414_1414;
    sb.push_back('{1, 32'h1010_1010, 0});
    sb.push_back('{0, 32'h0000_8888, 0});
    sb.push_back('{1, 32'h1414_1414, 0});
    fork
      begin
        do_txn(1, 0, 32'h1000_0010, 32'h0, l1);
        do_txn(1, 0, 32'h1000_0014, 32'h0, l2);
      end
      do_txn(0, 0, 32'h0000_0008, 32'h0, l3);
    join
    check("conflict_drained", 32'(sb.size()), 32'd0);

    // Timeout: backend never acks
    back_en     = 1'b0;
    mreq_cycles = 0;
    sb.push_back('{1, 32'h0, 1});
    do_txn(1, 0, 32'h1000_0020, 32'h0, lat);
    check("tmo_mreq_cycles", 32'(mreq_cycles), 32'd15);
    check("tmo_latency", 32'(lat), 32'd16);

    // Reset in the middle of ISSUE aborts; late mAck ignored
    n0    = n_ready;
    dAddr = 32'h1000_0020;
    dWe   = 1'b0;
    dReq  = 1'b1;
    repeat (5) @(negedge clk);
    check("mreq_before_reset", 32'(mReq), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("mreq_async_reset", 32'(mReq), 32'd0);
    check("dready_async_reset", 32'(dReady), 32'd0);
    dReq = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #2 force_ack = 1'b1;
    @(negedge clk);
    #2 force_ack = 1'b0;
    repeat (4) @(negedge clk);
    check("no_ready_after_abort", 32'(n_ready - n0), 32'd0);
    check("mreq_idle_after_ack", 32'(mReq), 32'd0);
    check("drdata_after_abort", dRData, 32'h0);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, compared %0d mismatched %0d", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
